// File: rtl/bullcow_pkg.sv
// Shared types and constants for the Bulls-and-Cows datapath.
// The code-entry front end and the game FSM both use this package.
//   digit_t        one decimal digit in a 4-bit field
//   code_t         four digits; element [3] is the first digit entered
//   entry_state_t  code-entry FSM states
package bullcow_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int MAX_DIGIT  = 9;

   typedef logic [3:0]      digit_t;
   typedef logic [3:0][3:0] code_t;

   typedef enum logic [1:0] {
      COLLECT,
      CHECK,
      OFFER,
      ERROR
   } entry_state_t;

   // True when no two of the four digits are equal (all 6 pairs compared).
   function automatic logic digits_distinct(input code_t c);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         for (int j = i + 1; j < NUM_DIGITS; j++) begin
            if (c[i] == c[j]) ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: synchroniser, debounce counter, rising-edge pulse.
//   clock    system clock
//   reset    asynchronous active-low reset
//   btn_i    raw asynchronous button, active high
//   press_o  one-cycle pulse when the debounced level rises
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);

   localparam int            CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_s;
   logic                   level_q;
   logic [CW-1:0]          cnt_q;
   logic                   press_q;

   assign sync_s  = sync_q[SYNC_STAGES-1];
   assign press_o = press_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
         press_q <= 1'b0;
         if (sync_s == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == TC) begin
            // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
            level_q <= sync_s;
            cnt_q   <= '0;
            press_q <= sync_s;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/bullcow_code_entry.sv
// Code entry stage: collects four digits, validates them, and offers the
// code to the game FSM on a valid/ready handshake.
//   clock, reset          system clock, async active-low reset
//   digit_in              switch value of the digit being entered
//   btn_enter, btn_clear  raw buttons, active high
//   code_ready            game accepts the offered code
//   code                  assembled code, code[3] = first digit
//   code_valid            code is checked and offered
//   entry_error           last entry attempt invalid, held until a press
//   digit_count           digits captured so far, 0-4
//
// state   | meaning
// COLLECT | capturing digits on enter presses, clear resets the entry
// CHECK   | one cycle: distinctness test of the four digits
// OFFER   | code_valid high until code_ready, buttons ignored
// ERROR   | entry_error high until the next enter or clear press
module bullcow_code_entry
   import bullcow_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [3:0]      digit_in,
   input  logic            btn_enter,
   input  logic            btn_clear,
   input  logic            code_ready,
   output logic [3:0][3:0] code,
   output logic            code_valid,
   output logic            entry_error,
   output logic [2:0]      digit_count
);

   logic         enter_p;
   logic         clear_p;
   entry_state_t state_q;
   code_t        code_q;
   logic [2:0]   count_q;
   logic         valid_q;
   logic         err_q;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_enter (
      .clock  (clock),
      .reset  (reset),
      .btn_i  (btn_enter),
      .press_o(enter_p)
   );

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_clear (
      .clock  (clock),
      .reset  (reset),
      .btn_i  (btn_clear),
      .press_o(clear_p)
   );

   assign code        = code_q;
   assign code_valid  = valid_q;
   assign entry_error = err_q;
   assign digit_count = count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= COLLECT;
         code_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               // Clear has priority; a simultaneous enter is dropped.
               if (clear_p) begin
                  code_q  <= '0;
                  count_q <= '0;
               end else if (enter_p) begin
                  if (digit_in <= digit_t'(MAX_DIGIT)) begin
                     code_q  <= {code_q[2:0], digit_in};
                     count_q <= count_q + 3'd1;
                     if (count_q == 3'(NUM_DIGITS - 1)) state_q <= CHECK;
                  end else begin
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end
               end
            end
            CHECK: begin
               if (digits_distinct(code_q)) begin
                  state_q <= OFFER;
                  valid_q <= 1'b1;
               end else begin
                  state_q <= ERROR;
                  err_q   <= 1'b1;
               end
            end
            OFFER: begin
               if (code_ready) begin
                  state_q <= COLLECT;
                  valid_q <= 1'b0;
                  code_q  <= '0;
                  count_q <= '0;
               end
            end
            ERROR: begin
               // The acknowledging press never captures a digit.
               if (enter_p || clear_p) begin
                  state_q <= COLLECT;
                  err_q   <= 1'b0;
                  code_q  <= '0;
                  count_q <= '0;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_bullcow_code_entry.sv
module tb_bullcow_code_entry;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [3:0]      digit_in = '0;
   logic            btn_enter = 1'b0;
   logic            btn_clear = 1'b0;
   logic            code_ready = 1'b0;
   logic [3:0][3:0] code;
   logic            code_valid;
   logic            entry_error;
   logic [2:0]      digit_count;

   bullcow_code_entry #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .digit_in   (digit_in),
      .btn_enter  (btn_enter),
      .btn_clear  (btn_clear),
      .code_ready (code_ready),
      .code       (code),
      .code_valid (code_valid),
      .entry_error(entry_error),
      .digit_count(digit_count)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Reference model: the digits entered so far plus two status flags.
   int digs[$];
   bit m_valid;
   bit m_err;
   bit seen_valid;

   function automatic logic [15:0] m_code();
      logic [15:0] v;
      v = '0;
      foreach (digs[i]) v = (v << 4) | 16'(digs[i]);
      return v;
   endfunction

   function automatic bit m_unique();
      for (int i = 0; i < digs.size(); i++)
         for (int j = i + 1; j < digs.size(); j++)
            if (digs[i] == digs[j]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void m_reset();
      digs.delete();
      m_valid = 1'b0;
      m_err   = 1'b0;
   endfunction

   function automatic void m_enter(input int d);
      if (m_valid) return;
      if (m_err) begin
         m_reset();
         return;
      end
      if (d > 9) begin
         m_err = 1'b1;
         return;
      end
      digs.push_back(d);
      if (digs.size() == 4) begin
         if (m_unique()) m_valid = 1'b1;
         else m_err = 1'b1;
      end
   endfunction

   function automatic void m_clear();
      if (m_valid) return;
      m_reset();
   endfunction

   // Hold the button(s) for 'hold' cycles then release and let things settle.
   task automatic press(input bit ent, input bit clr, input int hold);
      seen_valid = 1'b0;
      @(negedge clock);
      btn_enter = ent;
      btn_clear = clr;
      repeat (hold) begin
         @(negedge clock);
         if (code_valid) seen_valid = 1'b1;
      end
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      repeat (12) begin
         @(negedge clock);
         if (code_valid) seen_valid = 1'b1;
      end
   endtask

   task automatic enter_digit(input int d);
      digit_in = 4'(d);
      press(1'b1, 1'b0, 8);
      m_enter(d);
   endtask

   task automatic do_clear();
      press(1'b0, 1'b1, 8);
      m_clear();
   endtask

   task automatic handshake();
      @(negedge clock);
      code_ready = 1'b1;
      @(negedge clock);
      code_ready = 1'b0;
      if (m_valid) m_reset();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      total++; if (code !== 16'h0)      begin bad++; $display("FAIL reset_code got=%h exp=0000", code); end
      total++; if (code_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", code_valid); end
      total++; if (entry_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", entry_error); end
      total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", digit_count); end
      @(negedge clock);
      reset = 1'b1;
      m_reset();
      repeat (3) @(negedge clock);
   endtask

   task automatic test_offer();
      enter_digit(1); enter_digit(2); enter_digit(3); enter_digit(4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         total++; if (code_valid !== 1'b1) begin bad++; $display("FAIL offer_valid cyc=%0d got=%b exp=1", i, code_valid); end
         total++; if (code !== 16'h1234)   begin bad++; $display("FAIL offer_code cyc=%0d got=%h exp=1234", i, code); end
         total++; if (digit_count !== 3'd4) begin bad++; $display("FAIL offer_count cyc=%0d got=%0d exp=4", i, digit_count); end
      end
      handshake();
      total++; if (code_valid !== 1'b0) begin bad++; $display("FAIL xfer_valid got=%b exp=0", code_valid); end
      total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL xfer_count got=%0d exp=0", digit_count); end
      total++; if (code !== 16'h0)      begin bad++; $display("FAIL xfer_code got=%h exp=0000", code); end
   endtask

   task automatic test_duplicate();
      enter_digit(1); enter_digit(2); enter_digit(2); enter_digit(3);
      total++; if (seen_valid !== 1'b0)  begin bad++; $display("FAIL dup_valid_rose got=%b exp=0", seen_valid); end
      total++; if (entry_error !== 1'b1) begin bad++; $display("FAIL dup_err got=%b exp=1", entry_error); end
      total++; if (code !== 16'h1223)    begin bad++; $display("FAIL dup_code got=%h exp=1223", code); end
      enter_digit(7);
      total++; if (entry_error !== 1'b0) begin bad++; $display("FAIL dup_ack_err got=%b exp=0", entry_error); end
      total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL dup_ack_count got=%0d exp=0", digit_count); end
      total++; if (code !== 16'h0)       begin bad++; $display("FAIL dup_ack_code got=%h exp=0000", code); end
   endtask

   task automatic test_range();
      enter_digit(5);
      enter_digit(10);
      total++; if (entry_error !== 1'b1) begin bad++; $display("FAIL range_err got=%b exp=1", entry_error); end
      total++; if (digit_count !== 3'd1) begin bad++; $display("FAIL range_count got=%0d exp=1", digit_count); end
      total++; if (code !== 16'h0005)    begin bad++; $display("FAIL range_code got=%h exp=0005", code); end
      do_clear();
      total++; if (entry_error !== 1'b0) begin bad++; $display("FAIL range_ack_err got=%b exp=0", entry_error); end
      total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL range_ack_count got=%0d exp=0", digit_count); end
   endtask

   task automatic test_hold();
      digit_in = 4'd8;
      press(1'b1, 1'b0, 3);
      total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", digit_count); end
      press(1'b1, 1'b0, 100);
      m_enter(8);
      total++; if (digit_count !== 3'd1) begin bad++; $display("FAIL hold_count got=%0d exp=1", digit_count); end
      total++; if (code !== 16'h0008)    begin bad++; $display("FAIL hold_code got=%h exp=0008", code); end
   endtask

   task automatic test_clear_wins();
      do_clear();
      enter_digit(5); enter_digit(6);
      total++; if (digit_count !== 3'd2) begin bad++; $display("FAIL cw_pre_count got=%0d exp=2", digit_count); end
      digit_in = 4'd7;
      press(1'b1, 1'b1, 8);
      m_clear();
      total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL cw_count got=%0d exp=0", digit_count); end
      total++; if (code !== 16'h0)       begin bad++; $display("FAIL cw_code got=%h exp=0000", code); end
   endtask

   task automatic test_reset_mid();
      enter_digit(3);
      @(negedge clock);
      btn_enter = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      #1;
      total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL rdb_count got=%0d exp=0", digit_count); end
      total++; if (code !== 16'h0)       begin bad++; $display("FAIL rdb_code got=%h exp=0000", code); end
      btn_enter = 1'b0;
      m_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (20) @(negedge clock);
      total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL rdb_after_count got=%0d exp=0", digit_count); end
      enter_digit(9); enter_digit(8); enter_digit(7); enter_digit(6);
      total++; if (code_valid !== 1'b1) begin bad++; $display("FAIL roff_pre_valid got=%b exp=1", code_valid); end
      #2;
      reset = 1'b0;
      #1;
      total++; if (code_valid !== 1'b0)  begin bad++; $display("FAIL roff_valid got=%b exp=0", code_valid); end
      total++; if (code !== 16'h0)       begin bad++; $display("FAIL roff_code got=%h exp=0000", code); end
      total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL roff_count got=%0d exp=0", digit_count); end
      total++; if (entry_error !== 1'b0) begin bad++; $display("FAIL roff_err got=%b exp=0", entry_error); end
      m_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (5) @(negedge clock);
      enter_digit(2);
      total++; if (digit_count !== 3'd1) begin bad++; $display("FAIL roff_collect got=%0d exp=1", digit_count); end
   endtask

   task automatic test_random();
      int op;
      int d;
      for (int n = 0; n < 60; n++) begin
         op = int'($urandom_range(0, 9));
         if (op < 7) begin
            d = (op == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            enter_digit(d);
         end else if (op == 7) begin
            do_clear();
         end else begin
            handshake();
         end
         total++; if (code !== m_code())                  begin bad++; $display("FAIL rnd_code n=%0d got=%h exp=%h", n, code, m_code()); end
         total++; if (digit_count !== 3'(digs.size()))    begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, digit_count, digs.size()); end
         total++; if (code_valid !== m_valid)             begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, code_valid, m_valid); end
         total++; if (entry_error !== m_err)              begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, entry_error, m_err); end
      end
   endtask

   initial begin
      test_reset();
      test_offer();
      test_duplicate();
      test_range();
      test_hold();
      test_clear_wins();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bullcow_code_entry.md
Name: bullcow_code_entry

Overview:
- Front-end entry stage for the Bulls-and-Cows game; sits directly upstream of the game FSM.
- Collects four decimal digits, one at a time, from a switch bank and a push-button.
- Validates the 4-digit code: every digit 0-9, all digits distinct.
- Offers a valid code to the game on a valid/ready handshake; the same path serves the secret-setup and guess phases.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles a synchronised button must hold before its debounced level changes (10 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop stages in each button synchroniser, minimum 2.

Ports:
- clock  input  1  system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- digit_in  input  4  switch value of the digit being entered.
- btn_enter  input  1  raw, asynchronous, active-high enter button.
- btn_clear  input  1  raw, asynchronous, active-high clear button.
- code_ready  input  1  game accepts the offered code this cycle.
- code  output  [3:0][3:0]  assembled code; code[3] is the first digit entered.
- code_valid  output  1  code is checked and offered.
- entry_error  output  1  last entry attempt was invalid; held until acknowledged.
- digit_count  output  3  digits captured so far, 0-4.

Behaviour:
- Reset (reset=0, asynchronous):
  - code=0, code_valid=0, entry_error=0, digit_count=0.
  - state=COLLECT; debounced levels=0; debounce counters=0.
- Button path, per button:
  - SYNC_STAGES synchroniser, then debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronised value equals the debounced level.
  - The debounced level toggles when the synchronised value has differed for DEBOUNCE_CYCLES consecutive cycles.
  - A rising edge of the debounced level gives a 1-cycle press pulse; holding the button yields exactly one pulse.
- Both press pulses in the same cycle: clear wins, enter is discarded.
- FSM states: COLLECT, CHECK, OFFER, ERROR.
- COLLECT:
  - enter press with digit_in<=9: code <= {code[2:0], digit_in}, digit_count+1.
  - When that press makes digit_count 4, go to CHECK next cycle.
  - enter press with digit_in>9: go to ERROR, no shift.
  - clear press: code=0, digit_count=0.
- CHECK (exactly 1 cycle):
  - All 6 digit pairs distinct: go to OFFER.
  - Otherwise: go to ERROR.
- OFFER:
  - code_valid=1; code and digit_count held stable.
  - Transfer occurs on the cycle code_valid && code_ready.
  - Next cycle: code_valid=0, digit_count=0, code=0, state=COLLECT.
  - Button presses are ignored in OFFER; valid is never withdrawn.
- ERROR:
  - entry_error=1 (level); code_valid=0.
  - The next enter or clear press only acknowledges: entry_error=0, code=0, digit_count=0, state=COLLECT.
  - The acknowledging press captures no digit.
- code_ready outside OFFER has no effect.
- Asynchronous reset in any state, including mid-debounce or mid-handshake, returns everything to reset values immediately.
- Digits sit in 4-bit fields, so the range check is only digit_in<=9.

Decomposition:
- Package bullcow_pkg:
  - typedef digit_t (logic[3:0]); typedef code_t (logic[3:0][3:0]).
  - typedef enum entry_state_t {COLLECT, CHECK, OFFER, ERROR}.
  - Constants NUM_DIGITS=4, MAX_DIGIT=9.
  - Shared with the game FSM.
- One sub-module, button_debounce (synchroniser + debounce counter + edge pulse), parameterised by DEBOUNCE_CYCLES and SYNC_STAGES, instantiated twice.
- Distinctness check and FSM live in bullcow_code_entry.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
1. Enter 1,2,3,4 with code_ready=0 for 10 cycles -> code=16'h1234 and code_valid=1 held stable. Raise code_ready -> next cycle code_valid=0, digit_count=0.
2. Enter 1,2,2,3 -> after CHECK, entry_error=1 and code_valid never rises. Enter press -> entry_error=0, digit_count=0, no digit captured.
3. digit_in=4'hA plus enter -> entry_error=1, digit_count unchanged, code unchanged.
4. Enter held low-high for 3 cycles -> no capture. Held for 100 cycles -> exactly one capture, digit_count+1.
5. Enter 5,6, then press clear and enter together -> digit_count=0, code=0, no capture.
6. Assert reset low mid-debounce and again during OFFER -> all outputs 0 immediately. After release the state is COLLECT, and a half-counted press does not produce a pulse.
